// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The core configuration record sets the datapath width.
package core_fetch_pkg;

   typedef struct packed {
      int unsigned XLEN;
   } core_conf_t;

   localparam core_conf_t DEFAULT_CONF = '{XLEN: 32};

   localparam int unsigned INST_BYTES = 4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/core_fetch_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response,
// and the instruction handshake toward decode.
interface core_fetch_if #(
   parameter int XLEN = 32
) ();

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
             imem_resp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
             imem_resp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
   );

endinterface

// File: rtl/core_fetch_fifo.sv
// Show-ahead synchronous FIFO holding {inst, pc} pairs, with a flush that
// empties it in one cycle. The head reads as zero while empty.
module core_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && (count_reg != (AW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= wdata;
   end

   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign rdata = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch front end: sequential PC generation with credit-limited
// requests, in-order response buffering, and redirect with stale-response drop.
module core_fetch
   import core_fetch_pkg::*;
#(
   parameter core_conf_t                 CONF       = DEFAULT_CONF,
   parameter logic [CONF.XLEN-1:0]       RESET_PC   = '0,
   parameter int                         FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   core_fetch_if.master bus
);

   localparam int XLEN = CONF.XLEN;
   localparam int CW   = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
   logic [CW-1:0]   outstanding_reg, outstanding_next;
   logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
   logic [CW-1:0]   fifo_count;
   logic [XLEN-1:0] redirect_target;
   logic [2*XLEN-1:0] fifo_rdata;
   logic            fifo_empty;
   logic            redirect, req_fire, resp_ok, push, pop;
   logic            unused_low_bits;

   assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_low_bits = &{1'b0, bus.redirect_pc[1:0]};

   assign redirect = bus.redirect_valid && (state_reg != BOOT);
   assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
   // A response with nothing outstanding is a protocol violation and is ignored.
   assign resp_ok  = bus.imem_resp_valid && (outstanding_reg != '0);
   assign push     = resp_ok && (state_reg == RUN) && !redirect;
   assign pop      = bus.inst_valid && bus.inst_ready;

   core_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .wdata ({bus.imem_resp_data, resp_pc_reg}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= BOOT;
         fetch_pc_reg    <= RESET_PC;
         resp_pc_reg     <= RESET_PC;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         resp_pc_reg     <= resp_pc_next;
         outstanding_reg <= outstanding_next;
         drop_cnt_reg    <= drop_cnt_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      fetch_pc_next    = req_fire ? fetch_pc_reg + XLEN'(INST_BYTES) : fetch_pc_reg;
      resp_pc_next     = push ? resp_pc_reg + XLEN'(INST_BYTES) : resp_pc_reg;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(resp_ok);
      drop_cnt_next    = drop_cnt_reg;
      case (state_reg)
         BOOT:  state_next = RUN;
         RUN:   state_next = RUN;
         FLUSH: begin
            if (resp_ok && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CW'(1);
            if (drop_cnt_next == '0) state_next = RUN;
         end
         default: state_next = BOOT;
      endcase
      // Everything still in flight after this cycle, including a request
      // accepted right now, belongs to the old path and must be dropped.
      if (redirect) begin
         fetch_pc_next = redirect_target;
         resp_pc_next  = redirect_target;
         drop_cnt_next = outstanding_next;
         state_next    = (outstanding_next != '0) ? FLUSH : RUN;
      end
   end

   always_comb begin
      bus.imem_req_valid = (state_reg == RUN) &&
                           (({1'b0, outstanding_reg} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
      bus.imem_req_addr  = fetch_pc_reg;
      bus.inst_valid     = !fifo_empty;
      bus.inst           = fifo_rdata[2*XLEN-1:XLEN];
      bus.inst_pc        = fifo_rdata[XLEN-1:0];
   end

   always @(posedge clk) begin
      if (!rst && bus.imem_resp_valid)
         assert (outstanding_reg != '0);
   end

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: a behavioural instruction memory with
// selectable latency, and a scoreboard that checks every delivered instruction.
module tb_core_fetch;
   import core_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   core_fetch_if #(.XLEN(32)) bus ();

   core_fetch #(
      .CONF       (DEFAULT_CONF),
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   pend_t       pend [$];
   exp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          hs_cnt = 0;
   logic [31:0] exp_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
      end
   endtask

   // Advance one clock; the memory model then decides what it presents this cycle.
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      hs = bus.imem_req_valid && bus.imem_req_ready && !rst;
      a  = bus.imem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      if (rst) begin
         pend.delete();
      end else begin
         if (hs) begin
            pend.push_back('{a, cyc + lat - 1});
            hs_cnt++;
         end
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic deliver(input int n);
      int got;
      got = 0;
      for (int i = 0; i < 80 && got < n; i++) begin
         bus.inst_ready = 1'b1;
         if (bus.inst_valid) begin
            exp_q.push_back('{mem_word(exp_pc), exp_pc});
            exp_pc += 32'd4;
            got++;
         end
         tick();
      end
      bus.inst_ready = 1'b0;
      check("deliver_count", got, n);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic wait_two_outstanding();
      for (int i = 0; i < 30; i++) begin
         if (pend.size() == 2 && !bus.imem_resp_valid) break;
         tick();
      end
      check("two_outstanding", pend.size(), 2);
   endtask

   task automatic do_redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick();
      bus.redirect_valid = 1'b0;
      exp_pc = {target[31:2], 2'b00};
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_inst: got pc 0x%08h, expected no delivery", bus.inst_pc);
            end else begin
               e = exp_q.pop_front();
               $display("deliver pc=0x%08h inst=0x%08h", bus.inst_pc, bus.inst);
               check("inst_pc", bus.inst_pc, e.pc);
               check("inst", bus.inst, e.inst);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.inst_ready      = 1'b0;
      rst    = 1'b1;
      exp_pc = RST_PC;
      idle(3);

      check("rst_req_valid", bus.imem_req_valid, 0);
      check("rst_req_addr", bus.imem_req_addr, RST_PC);
      check("rst_inst_valid", bus.inst_valid, 0);
      check("rst_inst", bus.inst, 0);
      check("rst_inst_pc", bus.inst_pc, 0);

      // Reset release: BOOT cycle, then requests; first instruction 3 cycles in.
      rst = 1'b0;
      tick();
      check("first_req_valid", bus.imem_req_valid, 1);
      check("first_req_addr", bus.imem_req_addr, 32'h0000_0100);
      check("inst_valid_c1", bus.inst_valid, 0);
      tick();
      check("inst_valid_c2", bus.inst_valid, 0);
      tick();
      check("inst_valid_c3", bus.inst_valid, 1);

      // Decode stalled: credits stop fetching at two requests.
      idle(5);
      check("credit_req_valid", bus.imem_req_valid, 0);
      check("credit_req_count", hs_cnt, 2);
      check("credit_head_pc", bus.inst_pc, 32'h0000_0100);
      deliver(6);
      idle(6);

      // Memory not ready: request holds with a stable address.
      bus.imem_req_ready = 1'b0;
      deliver(1);
      for (int i = 0; i < 5; i++) begin
         check("stall_req_valid", bus.imem_req_valid, 1);
         check("stall_req_addr", bus.imem_req_addr, 32'h0000_0120);
         tick();
      end
      bus.imem_req_ready = 1'b1;
      idle(4);

      // Three-cycle memory, redirect with two requests in flight.
      lat = 3;
      deliver(2);
      wait_two_outstanding();
      do_redirect(32'h0000_2002);
      check("redir_inst_valid", bus.inst_valid, 0);
      for (int i = 0; i < 12 && !bus.imem_req_valid; i++) tick();
      check("redir_req_valid", bus.imem_req_valid, 1);
      check("redir_req_addr", bus.imem_req_addr, 32'h0000_2000);
      deliver(1);
      idle(10);

      // Redirect coinciding with a response and a pop.
      lat = 1;
      begin : coincide
         logic found;
         found = 1'b0;
         for (int i = 0; i < 30 && !found; i++) begin
            bus.inst_ready = 1'b1;
            if (bus.inst_valid) begin
               exp_q.push_back('{mem_word(exp_pc), exp_pc});
               exp_pc += 32'd4;
            end
            if (i >= 2 && bus.inst_valid && bus.imem_resp_valid) begin
               found = 1'b1;
               do_redirect(32'h0000_3000);
            end else begin
               tick();
            end
         end
         bus.inst_ready = 1'b0;
         check("coincide_found", found, 1);
      end
      check("coincide_popped", exp_q.size(), 0);
      check("coincide_fifo_empty", bus.inst_valid, 0);
      deliver(2);
      idle(6);

      // Address wrap-around at the top of the space.
      do_redirect(32'hFFFF_FFFC);
      check("wrap_inst_valid", bus.inst_valid, 0);
      check("wrap_req_valid", bus.imem_req_valid, 1);
      check("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      deliver(3);
      idle(6);

      // Reset in the middle of a flush.
      lat = 3;
      deliver(2);
      wait_two_outstanding();
      do_redirect(32'h0000_4000);
      rst = 1'b1;
      tick();
      check("mid_rst_req_valid", bus.imem_req_valid, 0);
      check("mid_rst_req_addr", bus.imem_req_addr, RST_PC);
      check("mid_rst_inst_valid", bus.inst_valid, 0);
      check("mid_rst_inst", bus.inst, 0);
      check("mid_rst_inst_pc", bus.inst_pc, 0);
      lat = 1;
      tick();
      rst    = 1'b0;
      exp_pc = RST_PC;
      deliver(2);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
